// File: rtl/dot4_requester.sv
// ---------------------------------------------------------------------------
// dot4_requester
//
// Collects four (weight, activation) operand pairs from an upstream
// valid/ready stream into lanes a..d, launches a shared-multiplier engine
// with a one-cycle start pulse, waits (bounded by TIMEOUT cycles) for the
// engine's completion pulse, then presents the engine result downstream on
// a valid/ready port. Transactions never overlap: operands are accepted only
// while collecting.
//
// Handshake rule (both streams): a transfer happens on a rising clk edge
// where valid and ready are both 1. The sender holds valid and its payload
// stable until that edge; ready may change at any time.
//
// Ports
//   clk         in   clock, rising edge
//   rstb        in   asynchronous active-low reset
//   in_valid    in   upstream operand pair valid
//   in_ready    out  block accepts an operand pair (only while collecting)
//   in_w        in   [WIDTH]   weight operand
//   in_x        in   [WIDTH]   activation operand
//   eng_w       out  [4*WIDTH] weight lanes, lane k at [WIDTH*k +: WIDTH]
//   eng_x       out  [4*WIDTH] activation lanes, same layout
//   eng_start   out  one-cycle engine start pulse
//   eng_done    in   engine completion pulse (only observed while waiting)
//   eng_result  in   [WIDTH]   engine result, valid with eng_done
//   res_valid   out  result available downstream
//   res_ready   in   downstream accepts the result
//   res_data    out  [WIDTH]   result (engine value, or 0 on timeout)
//   res_err     out  result ended by timeout
//   dbg_state   out  [2]       current FSM state (0 COLLECT, 1 START,
//                              2 WAIT, 3 RESP)
// ---------------------------------------------------------------------------
module dot4_requester #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_w,
  input  logic [WIDTH-1:0]     in_x,
  output logic [4*WIDTH-1:0]   eng_w,
  output logic [4*WIDTH-1:0]   eng_x,
  output logic                 eng_start,
  input  logic                 eng_done,
  input  logic [WIDTH-1:0]     eng_result,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [WIDTH-1:0]     res_data,
  output logic                 res_err,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_START   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic [1:0]    cnt;
  logic [CW-1:0] wait_cnt;

  assign dbg_state = state;

  // All outputs are flops updated alongside the state, so every output
  // changes only on a clock edge (or asynchronously on reset).
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= S_COLLECT;
      cnt       <= 2'd0;
      wait_cnt  <= '0;
      eng_w     <= '0;
      eng_x     <= '0;
      in_ready  <= 1'b1;
      eng_start <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
    end else begin
      case (state)
        S_COLLECT: begin
          if (in_valid && in_ready) begin
            eng_w[WIDTH*int'(cnt) +: WIDTH] <= in_w;
            eng_x[WIDTH*int'(cnt) +: WIDTH] <= in_x;
            cnt <= cnt + 2'd1;               // wraps to 0 after lane d
            if (cnt == 2'd3) begin
              state     <= S_START;
              in_ready  <= 1'b0;
              eng_start <= 1'b1;
            end
          end
        end

        S_START: begin
          // eng_done is deliberately not looked at here.
          eng_start <= 1'b0;
          wait_cnt  <= '0;
          state     <= S_WAIT;
        end

        S_WAIT: begin
          // Completion wins over a timeout that fires in the same cycle.
          if (eng_done) begin
            res_data  <= eng_result;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            state     <= S_RESP;
          end else if (wait_cnt == WAIT_LAST) begin
            res_data  <= '0;
            res_err   <= 1'b1;
            res_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
            cnt       <= 2'd0;
            state     <= S_COLLECT;
          end
        end

        default: begin
          state     <= S_COLLECT;
          in_ready  <= 1'b1;
          eng_start <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot4_requester.sv
`timescale 1ns/1ps
module tb_dot4_requester;

  localparam int W  = 16;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid, in_ready;
  logic [W-1:0]     in_w, in_x;
  logic [4*W-1:0]   eng_w, eng_x;
  logic             eng_start, eng_done;
  logic [W-1:0]     eng_result;
  logic             res_valid, res_ready;
  logic [W-1:0]     res_data;
  logic             res_err;
  logic [1:0]       dbg_state;

  dot4_requester #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rstb(rstb),
    .in_valid(in_valid), .in_ready(in_ready), .in_w(in_w), .in_x(in_x),
    .eng_w(eng_w), .eng_x(eng_x), .eng_start(eng_start),
    .eng_done(eng_done), .eng_result(eng_result),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];   // expected results, pushed per transaction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One transaction record: inputs plus expected outputs.
  typedef struct {
    logic [4*W-1:0] w;
    logic [4*W-1:0] x;
    int             gaps;      // idle in_valid cycles before each beat
    int             delay;     // cycles after eng_start that eng_done pulses
    logic [W-1:0]   result;
    int             hold;      // cycles res_ready held low in RESP
    int             exp_cycle; // cycles after eng_start that res_valid shows
    logic [W-1:0]   exp_data;
    logic           exp_err;
  } vec_t;

  // Reference: engine answer counts if it arrives within TO waiting cycles,
  // otherwise the result is an error with zero data after TO waiting cycles.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (v.delay <= TO) begin
      r.exp_cycle = v.delay + 1;
      r.exp_data  = v.result;
      r.exp_err   = 1'b0;
    end else begin
      r.exp_cycle = TO + 1;
      r.exp_data  = '0;
      r.exp_err   = 1'b1;
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rstb = 1'b0;
    #1;
    chk("rst_eng_w", eng_w, '0);
    chk("rst_eng_x", eng_x, '0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, '0);
    chk("rst_res_err", res_err, 0);
    @(posedge clk);
    @(negedge clk);
    rstb = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
  endtask

  task automatic send_beat(input logic [W-1:0] w, input logic [W-1:0] x, input int gaps);
    for (int g = 0; g < gaps; g++) begin
      in_valid   = 1'b0;
      in_w       = W'($urandom());
      in_x       = W'($urandom());
      eng_done   = 1'($urandom_range(0, 1));
      eng_result = W'($urandom());
      @(posedge clk);
      @(negedge clk);
      chk("gap_in_ready", in_ready, 1);
      chk("gap_res_valid", res_valid, 0);
    end
    eng_done = 1'($urandom_range(0, 1));
    in_valid = 1'b1;
    in_w     = w;
    in_x     = x;
    chk("beat_in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    int resp_c;
    logic [W-1:0] exp_d;
    for (int i = 0; i < 4; i++) send_beat(v.w[W*i +: W], v.x[W*i +: W], v.gaps);
    // cycle 0: the START cycle; a stray done pulse here must be ignored
    eng_done   = 1'b1;
    eng_result = W'($urandom());
    chk("start_pulse", eng_start, 1);
    chk("lanes_w", eng_w, v.w);
    chk("lanes_x", eng_x, v.x);
    chk("start_in_ready", in_ready, 0);
    exp_q.push_back(v.exp_data);
    resp_c = -1;
    for (int c = 1; c <= TO + 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      eng_done = 1'b0;
      if (res_valid) begin
        resp_c = c;
        break;
      end
      chk("start_once", eng_start, 0);
      chk("wait_lanes_w", eng_w, v.w);
      chk("wait_lanes_x", eng_x, v.x);
      eng_done   = (c == v.delay);
      eng_result = (c == v.delay) ? v.result : W'($urandom());
    end
    eng_done = 1'b0;
    chk("resp_cycle", 64'(resp_c), 64'(v.exp_cycle));
    exp_d = exp_q.pop_front();
    if (resp_c < 0) begin
      do_reset();
      return;
    end
    chk("res_data", res_data, exp_d);
    chk("res_err", res_err, v.exp_err);
    for (int h = 0; h < v.hold; h++) begin
      res_ready = 1'b0;
      in_valid  = 1'b1;                  // must not be accepted in RESP
      in_w      = W'($urandom());
      in_x      = W'($urandom());
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, exp_d);
      chk("hold_err", res_err, v.exp_err);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk("done_res_valid", res_valid, 0);
    chk("done_in_ready", in_ready, 1);
    chk("no_overlap_w", eng_w, v.w);
  endtask

  // ---------------- test ----------------
  vec_t tbl[6];

  initial begin
    in_valid = 0; in_w = '0; in_x = '0;
    eng_done = 0; eng_result = '0; res_ready = 0;

    // Expected values written out by hand from the timing rules.
    tbl[0] = '{w: {16'd7, 16'd5, 16'd3, 16'd1}, x: {16'd8, 16'd6, 16'd4, 16'd2},
               gaps: 0, delay: 3, result: 16'd100, hold: 5,
               exp_cycle: 4, exp_data: 16'd100, exp_err: 1'b0};
    tbl[1] = '{w: 64'h1111_2222_3333_4444, x: 64'h5555_6666_7777_8888,
               gaps: 0, delay: 50, result: 16'hBEEF, hold: 0,
               exp_cycle: 9, exp_data: 16'd0, exp_err: 1'b1};
    tbl[2] = '{w: 64'hA0A0_B0B0_C0C0_D0D0, x: 64'h0102_0304_0506_0708,
               gaps: 0, delay: 8, result: 16'h1234, hold: 1,
               exp_cycle: 9, exp_data: 16'h1234, exp_err: 1'b0};
    tbl[3] = '{w: 64'hFFFF_0000_FFFF_0000, x: 64'h0000_FFFF_0000_FFFF,
               gaps: 0, delay: 9, result: 16'h5678, hold: 2,
               exp_cycle: 9, exp_data: 16'd0, exp_err: 1'b1};
    tbl[4] = '{w: 64'h0009_0008_0007_0006, x: 64'h0004_0003_0002_0001,
               gaps: 2, delay: 1, result: 16'hFFFF, hold: 0,
               exp_cycle: 2, exp_data: 16'hFFFF, exp_err: 1'b0};
    tbl[5] = '{w: 64'hDEAD_BEEF_CAFE_F00D, x: 64'h1357_9BDF_2468_ACE0,
               gaps: 1, delay: 5, result: 16'h0000, hold: 3,
               exp_cycle: 6, exp_data: 16'h0000, exp_err: 1'b0};

    do_reset();
    chk("init_res_valid", res_valid, 0);
    chk("init_eng_start", eng_start, 0);

    for (int i = 0; i < 6; i++) run_txn(tbl[i]);

    // Reset after two beats: the next transaction must use only new beats.
    send_beat(16'hAAAA, 16'hBBBB, 0);
    send_beat(16'hCCCC, 16'hDDDD, 0);
    do_reset();
    begin
      vec_t v;
      v = '{w: 64'h0044_0033_0022_0011, x: 64'h0088_0077_0066_0055,
            gaps: 0, delay: 2, result: 16'h0ABC, hold: 0,
            exp_cycle: 3, exp_data: 16'h0ABC, exp_err: 1'b0};
      run_txn(v);
    end

    // Reset while waiting on the engine: the late done must not produce a result.
    for (int i = 0; i < 4; i++) send_beat(W'(i + 1), W'(i + 5), 0);
    @(posedge clk);
    @(negedge clk);
    do_reset();
    eng_done = 1'b1;
    eng_result = 16'h7777;
    @(posedge clk);
    @(negedge clk);
    eng_done = 1'b0;
    chk("post_rst_res_valid", res_valid, 0);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_res_data", res_data, '0);

    // Randomized transactions against the reference model.
    for (int n = 0; n < 25; n++) begin
      vec_t v;
      v.w      = {$urandom(), $urandom()};
      v.x      = {$urandom(), $urandom()};
      v.gaps   = $urandom_range(0, 2);
      v.delay  = $urandom_range(1, TO + 3);
      v.result = W'($urandom());
      v.hold   = $urandom_range(0, 3);
      run_txn(model(v));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
